beta_mem_arbiter: RTL and testbench

- Shares the single external memory port (MemAddress/MemDataIn/MemDataOut/MemDataReady/MemReadEnable/MemWriteEnable) between the MMU's two miss paths.
  - Requester A: instruction-side cache line fill.
  - Requester B: data-side line fill or single-word write-through.
- Sequences each line fill as LINE_WORDS word reads and streams the words back with an index, so the MMU can write its cache data arrays.
- Arbitration is round-robin when both sides are pending.

---
 rtl/beta_mem_pkg.sv | 23 ++
 rtl/beta_mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_beta_mem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/beta_mem_pkg.sv
// beta_mem_pkg
//   Shared types and constants for the external memory arbiter.
//   arb_state_t : arbiter sequencing states
//   grant_t     : identity of the requester that owns (or last owned) memory
//   LINE_WORDS_DEF : default number of 32-bit words per cache line
package beta_mem_pkg;

    localparam int LINE_WORDS_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        FILL_A,
        FILL_B,
        WRITE_B,
        DONE
    } arb_state_t;

    typedef enum logic {
        GRANT_A,
        GRANT_B
    } grant_t;

endpackage

// File: rtl/beta_mem_arbiter.sv
// beta_mem_arbiter
//   Shares the single external memory port between the MMU's instruction-side
//   line fill (requester A) and data-side line fill / single-word write-through
//   (requester B). Line fills are issued as LINE_WORDS sequential word reads;
//   each returned word is streamed back one cycle later with its index.
//   Simultaneous requests are resolved round-robin.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   a_req/a_addr             : A fill request (held until a_done) and address
//   a_word/_valid/_idx       : registered fill word stream back to A
//   a_done                   : one-cycle completion pulse for A
//   b_req/b_write/b_addr/b_wdata : B request, 1 = single-word write
//   b_word/_valid/_idx       : registered fill word stream back to B
//   b_done                   : one-cycle completion pulse for B
//   MemAddress/MemDataOut/MemDataIn/MemDataReady/MemReadEnable/MemWriteEnable
//                            : external memory port
module beta_mem_arbiter
    import beta_mem_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             a_req,
    input  logic [31:0]      a_addr,
    output logic [31:0]      a_word,
    output logic             a_word_valid,
    output logic [IDX_W-1:0] a_word_idx,
    output logic             a_done,

    input  logic             b_req,
    input  logic             b_write,
    input  logic [31:0]      b_addr,
    input  logic [31:0]      b_wdata,
    output logic [31:0]      b_word,
    output logic             b_word_valid,
    output logic [IDX_W-1:0] b_word_idx,
    output logic             b_done,

    output logic [31:0]      MemAddress,
    output logic [31:0]      MemDataOut,
    input  logic [31:0]      MemDataIn,
    input  logic             MemDataReady,
    output logic             MemReadEnable,
    output logic             MemWriteEnable
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    arb_state_t       state_q, state_d;
    grant_t           last_grant_q, last_grant_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [31:0]      base_q, base_d;

    logic [31:0]      a_word_q, a_word_d;
    logic [31:0]      b_word_q, b_word_d;
    logic [IDX_W-1:0] a_idx_q, a_idx_d;
    logic [IDX_W-1:0] b_idx_q, b_idx_d;
    logic             a_vld_q, a_vld_d;
    logic             b_vld_q, b_vld_d;

    logic             grant_a;
    logic             rd_en;
    logic             wr_en;
    logic             unused_base_bits;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_B;
            cnt_q        <= '0;
            base_q       <= '0;
            a_word_q     <= '0;
            b_word_q     <= '0;
            a_idx_q      <= '0;
            b_idx_q      <= '0;
            a_vld_q      <= 1'b0;
            b_vld_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            base_q       <= base_d;
            a_word_q     <= a_word_d;
            b_word_q     <= b_word_d;
            a_idx_q      <= a_idx_d;
            b_idx_q      <= b_idx_d;
            a_vld_q      <= a_vld_d;
            b_vld_q      <= b_vld_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        base_d       = base_q;
        a_word_d     = a_word_q;
        b_word_d     = b_word_q;
        a_idx_d      = a_idx_q;
        b_idx_d      = b_idx_q;
        a_vld_d      = 1'b0;
        b_vld_d      = 1'b0;
        grant_a      = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the side that did not win last time is served.
                grant_a = a_req && (!b_req || (last_grant_q == GRANT_B));
                if (grant_a) begin
                    state_d      = FILL_A;
                    base_d       = a_addr;
                    last_grant_d = GRANT_A;
                    cnt_d        = '0;
                end else if (b_req) begin
                    if (b_write) begin
                        state_d = WRITE_B;
                    end else begin
                        state_d = FILL_B;
                    end
                    base_d       = b_addr;
                    last_grant_d = GRANT_B;
                    cnt_d        = '0;
                end
            end

            FILL_A, FILL_B: begin
                if (MemDataReady) begin
                    if (state_q == FILL_A) begin
                        a_word_d = MemDataIn;
                        a_idx_d  = cnt_q;
                        a_vld_d  = 1'b1;
                    end else begin
                        b_word_d = MemDataIn;
                        b_idx_d  = cnt_q;
                        b_vld_d  = 1'b1;
                    end
                    cnt_d = cnt_q + IDX_W'(1);
                    // The final word's valid lands in DONE, alongside done.
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end

            WRITE_B: begin
                if (MemDataReady) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Enables drop combinationally while rst is high so an abort takes
    // effect in the very cycle reset is sampled.
    assign rd_en = !rst && ((state_q == FILL_A) || (state_q == FILL_B));
    assign wr_en = !rst && (state_q == WRITE_B);

    assign MemReadEnable  = rd_en;
    assign MemWriteEnable = wr_en;
    assign MemAddress     = rd_en ? {base_q[31:IDX_W+2], cnt_q, 2'b00} :
                            wr_en ? {base_q[31:2], 2'b00} : 32'h0;
    assign MemDataOut     = wr_en ? b_wdata : 32'h0;

    assign a_word       = a_word_q;
    assign a_word_idx   = a_idx_q;
    assign a_word_valid = a_vld_q && !rst;
    assign a_done       = !rst && (state_q == DONE) && (last_grant_q == GRANT_A);

    assign b_word       = b_word_q;
    assign b_word_idx   = b_idx_q;
    assign b_word_valid = b_vld_q && !rst;
    assign b_done       = !rst && (state_q == DONE) && (last_grant_q == GRANT_B);

    // Byte-offset bits of the latched address are never driven onto the bus.
    assign unused_base_bits = ^base_q[1:0];

endmodule

// File: tb/tb_beta_mem_arbiter.sv
module tb_beta_mem_arbiter;

    localparam int LW = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0;
    logic [31:0] a_addr = '0;
    logic [31:0] a_word;
    logic        a_word_valid;
    logic [3:0]  a_word_idx;
    logic        a_done;
    logic        b_req = 1'b0;
    logic        b_write = 1'b0;
    logic [31:0] b_addr = '0;
    logic [31:0] b_wdata = '0;
    logic [31:0] b_word;
    logic        b_word_valid;
    logic [3:0]  b_word_idx;
    logic        b_done;
    logic [31:0] MemAddress;
    logic [31:0] MemDataOut;
    logic [31:0] MemDataIn;
    logic        MemDataReady = 1'b0;
    logic        MemReadEnable;
    logic        MemWriteEnable;

    int n_checks = 0;
    int n_err    = 0;

    beta_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_word(a_word), .a_word_valid(a_word_valid),
        .a_word_idx(a_word_idx), .a_done(a_done),
        .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_word(b_word), .b_word_valid(b_word_valid), .b_word_idx(b_word_idx), .b_done(b_done),
        .MemAddress(MemAddress), .MemDataOut(MemDataOut), .MemDataIn(MemDataIn),
        .MemDataReady(MemDataReady), .MemReadEnable(MemReadEnable), .MemWriteEnable(MemWriteEnable)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed function of the word address.
    function automatic logic [31:0] mem_fn(input logic [31:0] ad);
        return {ad[15:0] ^ 16'hC3A5, ~ad[31:16]} + ad;
    endfunction

    assign MemDataIn = mem_fn(MemAddress);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory responder with wait states ----------------
    int   wait_mode  = 0;   // 0: none, 1: fixed wfix, 2: random 0..5
    int   wfix       = 0;
    logic idle_ready = 1'b0;
    int   left       = 0;
    logic en_prev    = 1'b0;

    function automatic int pick_wait();
        if (wait_mode == 0) return 0;
        if (wait_mode == 1) return wfix;
        return int'($urandom_range(0, 5));
    endfunction

    always @(posedge clk) begin
        logic en;
        #2;
        en = MemReadEnable || MemWriteEnable;
        if (en && (!en_prev || MemDataReady)) left = pick_wait();
        if (en) begin
            if (left == 0) MemDataReady = 1'b1;
            else begin
                MemDataReady = 1'b0;
                left--;
            end
        end else begin
            MemDataReady = idle_ready;
        end
        en_prev = en;
    end

    // ---------------- transaction-level reference model ----------------
    int          m_phase = 0;   // 0 idle, 1 transfer, 2 done
    int          m_side  = 0;   // 0 = A, 1 = B
    int          m_last  = 1;
    logic        m_write = 1'b0;
    logic [31:0] m_base  = '0;
    int          m_beats = 0;
    logic        m_a_vld = 1'b0, m_b_vld = 1'b0;
    logic [3:0]  m_a_idx = '0, m_b_idx = '0;
    logic [31:0] m_a_word = '0, m_b_word = '0;
    logic        started = 1'b0;

    always @(posedge clk) begin
        logic [31:0] cur;
        cur = m_base + 32'(4 * m_beats);
        m_a_vld = 1'b0;
        m_b_vld = 1'b0;
        if (rst) begin
            m_phase = 0;
            m_last  = 1;
            m_a_word = '0; m_b_word = '0; m_a_idx = '0; m_b_idx = '0;
        end else if (m_phase == 0) begin
            if (a_req && (!b_req || m_last == 1)) begin
                m_side = 0; m_write = 1'b0; m_last = 0;
                m_base = a_addr & ~32'(LW * 4 - 1);
                m_beats = 0; m_phase = 1;
            end else if (b_req) begin
                m_side = 1; m_write = b_write; m_last = 1;
                m_base = b_write ? (b_addr & ~32'h3) : (b_addr & ~32'(LW * 4 - 1));
                m_beats = 0; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (MemDataReady) begin
                if (m_write) m_phase = 2;
                else begin
                    if (m_side == 0) begin
                        m_a_vld = 1'b1; m_a_idx = 4'(m_beats); m_a_word = mem_fn(cur);
                    end else begin
                        m_b_vld = 1'b1; m_b_idx = 4'(m_beats); m_b_word = mem_fn(cur);
                    end
                    m_beats++;
                    if (m_beats == LW) m_phase = 2;
                end
            end
        end else begin
            m_phase = 0;
        end
        started = 1'b1;
    end

    // ---------------- per-cycle comparison against the model ----------------
    always @(negedge clk) begin
        logic e_rd, e_wr, e_av, e_bv, e_ad, e_bd;
        logic [31:0] e_addr, e_dout;
        if (started) begin
            e_rd = !rst && m_phase == 1 && !m_write;
            e_wr = !rst && m_phase == 1 && m_write;
            e_addr = e_rd ? m_base + 32'(4 * m_beats) : (e_wr ? m_base : 32'h0);
            e_dout = e_wr ? b_wdata : 32'h0;
            e_av = !rst && m_a_vld;
            e_bv = !rst && m_b_vld;
            e_ad = !rst && m_phase == 2 && m_side == 0;
            e_bd = !rst && m_phase == 2 && m_side == 1;
            chk("rd_en", MemReadEnable, e_rd);
            chk("wr_en", MemWriteEnable, e_wr);
            chk("mem_addr", MemAddress, e_addr);
            chk("mem_dout", MemDataOut, e_dout);
            chk("a_valid", a_word_valid, e_av);
            chk("b_valid", b_word_valid, e_bv);
            chk("a_done", a_done, e_ad);
            chk("b_done", b_done, e_bd);
            if (e_av) begin
                chk("a_word", a_word, m_a_word);
                chk("a_idx", a_word_idx, m_a_idx);
            end
            if (e_bv) begin
                chk("b_word", b_word, m_b_word);
                chk("b_idx", b_word_idx, m_b_idx);
            end
        end
    end

    // ---------------- observation counters for directed checks ----------------
    int          cyc = 0;
    int          cnt_a_vld = 0, cnt_b_vld = 0, cnt_a_done = 0, cnt_b_done = 0;
    int          rd_cycles = 0, wr_cycles = 0, overlap = 0;
    int          first_a_idx = -1, done_idx = -1, done_vld = -1;
    int          a_done_cyc = -1, first_wr_cyc = -1;
    logic [31:0] last_wr_addr = '0, last_wr_data = '0;
    logic [31:0] rd_addr_q[$];
    int          done_log[$];

    always @(negedge clk) begin
        cyc++;
        if (MemReadEnable) rd_cycles++;
        if (MemReadEnable && MemWriteEnable) overlap++;
        if (MemReadEnable && MemDataReady) rd_addr_q.push_back(MemAddress);
        if (MemWriteEnable) begin
            wr_cycles++;
            last_wr_addr = MemAddress;
            last_wr_data = MemDataOut;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
        end
        if (a_word_valid) begin
            if (cnt_a_vld == 0) first_a_idx = int'(a_word_idx);
            cnt_a_vld++;
        end
        if (b_word_valid) cnt_b_vld++;
        if (a_done) begin
            cnt_a_done++;
            a_done_cyc = cyc;
            done_idx = int'(a_word_idx);
            done_vld = int'(a_word_valid);
        end
        if (b_done) cnt_b_done++;
    end

    task automatic clear_obs();
        cnt_a_vld = 0; cnt_b_vld = 0; cnt_a_done = 0; cnt_b_done = 0;
        rd_cycles = 0; wr_cycles = 0; overlap = 0;
        first_a_idx = -1; done_idx = -1; done_vld = -1;
        a_done_cyc = -1; first_wr_cyc = -1;
        rd_addr_q.delete();
        done_log.delete();
    endtask

    // Wait for n completions; each requester drops req on seeing its done.
    task automatic serve(input int n, input int budget);
        int got = 0;
        int c = 0;
        while (got < n && c < budget) begin
            @(negedge clk);
            c++;
            if (a_done) begin a_req = 1'b0; done_log.push_back(0); got++; end
            if (b_done) begin b_req = 1'b0; done_log.push_back(1); got++; end
        end
        chk("serve_count", got, n);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_word", a_word, 32'h0);
        chk("rst_a_idx", a_word_idx, 4'h0);
        chk("rst_b_word", b_word, 32'h0);
        chk("rst_mem_addr", MemAddress, 32'h0);
        chk("rst_rd_en", MemReadEnable, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Test 1: plain A fill, memory ready every cycle.
        clear_obs();
        wait_mode = 0;
        a_addr = 32'h0000_1234; a_req = 1'b1;
        serve(1, 300);
        chk("t1_nvalid", cnt_a_vld, 16);
        chk("t1_naddr", rd_addr_q.size(), 16);
        chk("t1_addr0", rd_addr_q.size() > 0 ? rd_addr_q[0] : 32'hX, 32'h0000_1200);
        chk("t1_addr15", rd_addr_q.size() > 15 ? rd_addr_q[15] : 32'hX, 32'h0000_123C);
        chk("t1_done_idx", done_idx, 15);
        chk("t1_done_vld", done_vld, 1);
        chk("t1_b_word", b_word, 32'h0);
        chk("t1_b_nvalid", cnt_b_vld, 0);

        // Test 2: B single-word write with 3 wait states.
        clear_obs();
        wait_mode = 1; wfix = 3;
        b_write = 1'b1; b_addr = 32'h0000_0403; b_wdata = 32'hDEAD_BEEF; b_req = 1'b1;
        serve(1, 100);
        chk("t2_wr_cycles", wr_cycles, 4);
        chk("t2_wr_addr", last_wr_addr, 32'h0000_0400);
        chk("t2_wr_data", last_wr_data, 32'hDEAD_BEEF);
        chk("t2_rd_cycles", rd_cycles, 0);
        chk("t2_b_done", cnt_b_done, 1);
        chk("t2_b_nvalid", cnt_b_vld, 0);

        // Test 3: simultaneous requests after A/B history ending with B.
        clear_obs();
        wait_mode = 0;
        b_write = 1'b0; b_addr = 32'h0000_8000; a_addr = 32'h0000_1000;
        a_req = 1'b1; b_req = 1'b1;
        serve(2, 400);
        chk("t3_order0", done_log.size() > 0 ? done_log[0] : -1, 0);
        chk("t3_order1", done_log.size() > 1 ? done_log[1] : -1, 1);
        chk("t3_b_nvalid", cnt_b_vld, 16);

        // Test 4: A fill with random 0..5 wait states per word.
        clear_obs();
        wait_mode = 2;
        a_addr = 32'h0001_0040; a_req = 1'b1;
        serve(1, 400);
        chk("t4_nvalid", cnt_a_vld, 16);
        chk("t4_first_idx", first_a_idx, 0);
        chk("t4_addr15", rd_addr_q.size() > 15 ? rd_addr_q[15] : 32'hX, 32'h0001_007C);

        // Test 3 repeat: last winner was A, so B goes first.
        clear_obs();
        wait_mode = 0;
        a_req = 1'b1; b_req = 1'b1;
        serve(2, 400);
        chk("t3r_order0", done_log.size() > 0 ? done_log[0] : -1, 1);
        chk("t3r_order1", done_log.size() > 1 ? done_log[1] : -1, 0);

        // Test 5: reset in the middle of word 7 of an A fill.
        clear_obs();
        wait_mode = 1; wfix = 2;
        a_addr = 32'h0000_5000; a_req = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(MemReadEnable && MemAddress == 32'h0000_501C) && k < 200);
        chk("t5_reach_word7", MemAddress, 32'h0000_501C);
        @(posedge clk); #1;
        rst = 1'b1; a_req = 1'b0;
        @(negedge clk);
        chk("t5_rd_en_in_rst", MemReadEnable, 1'b0);
        chk("t5_wr_en_in_rst", MemWriteEnable, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("t5_no_done", cnt_a_done, 0);
        chk("t5_nvalid_before", cnt_a_vld, 7);
        // Stray ready strobes in IDLE/DONE must be ignored from here on.
        idle_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        clear_obs();
        wait_mode = 0;
        a_req = 1'b1;
        serve(1, 300);
        chk("t5_restart_idx", first_a_idx, 0);
        chk("t5_restart_n", cnt_a_vld, 16);
        chk("t5_restart_addr0", rd_addr_q.size() > 0 ? rd_addr_q[0] : 32'hX, 32'h0000_5000);
        idle_ready = 1'b0;

        // Test 6: B write request arrives during an A fill.
        clear_obs();
        a_addr = 32'h0000_2000; a_req = 1'b1;
        repeat (3) @(posedge clk); #1;
        b_write = 1'b1; b_addr = 32'h0000_3008; b_wdata = 32'h1234_5678; b_req = 1'b1;
        serve(2, 400);
        chk("t6_order0", done_log.size() > 0 ? done_log[0] : -1, 0);
        chk("t6_order1", done_log.size() > 1 ? done_log[1] : -1, 1);
        chk("t6_grant_gap", first_wr_cyc - a_done_cyc, 2);
        chk("t6_overlap", overlap, 0);
        chk("t6_wr_addr", last_wr_addr, 32'h0000_3008);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
